// File: rtl/dcp_pkg.sv
// dcp_pkg: shared definitions for the data-memory load command.
// Provides the command FSM state encoding, the ASCII constants used by the
// parser and message sender, the reply length, and a helper that returns
// the n-th byte of the "OK\r\n" / "ER\r\n" reply.
package dcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_WRITE,
    ST_DRAIN,
    ST_TX_MSG,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;

  localparam int MSG_LEN = 4;

  // Reply byte at position idx: {'O'|'E', 'K'|'R', CR, LF}
  function automatic logic [7:0] msg_byte(input logic is_err, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = is_err ? ASCII_E : ASCII_O;
      2'd1:    b = is_err ? ASCII_R : ASCII_K;
      2'd2:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dcp_msg_tx.sv
// dcp_msg_tx: sends the 4-byte reply ("OK\r\n" or "ER\r\n") over a
// valid/ready byte stream.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - one-cycle request to begin a reply
//   is_err    - reply kind, sampled with start (1 = "ER", 0 = "OK")
//   rdy_tx    - transmitter ready
//   d_tx      - byte being offered, held stable while vld_tx is high
//   vld_tx    - d_tx valid
//   done      - one-cycle pulse after the last byte is accepted
module dcp_msg_tx
  import dcp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_err,
  input  logic       rdy_tx,
  output logic [7:0] d_tx,
  output logic       vld_tx,
  output logic       done
);

  logic [1:0] idx;
  logic       err_q;

  // d_tx only advances on a completed handshake, so it stays put while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= 2'd0;
      err_q  <= 1'b0;
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        idx    <= 2'd0;
        err_q  <= is_err;
        d_tx   <= msg_byte(is_err, 2'd0);
        vld_tx <= 1'b1;
      end else if (vld_tx && rdy_tx) begin
        if (idx == 2'(MSG_LEN - 1)) begin
          vld_tx <= 1'b0;
          done   <= 1'b1;
        end else begin
          idx  <= idx + 2'd1;
          d_tx <= msg_byte(err_q, idx + 2'd1);
        end
      end
    end
  end

endmodule

// File: rtl/dcp_load_d.sv
// dcp_load_d: ASCII "load data memory" command.
// Parses "<addr> <word> <word> ...\r" (hex words, space separated) from the
// UART receive stream, writes each word to consecutive data-memory
// addresses starting at <addr>, then replies "OK\r\n" (or "ER\r\n" on a
// malformed line) and pulses finish.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   we                - start pulse (only honoured in IDLE)
//   finish, busy      - completion pulse, command in progress
//   d_rx/vld_rx/rdy_rx - received byte stream
//   d_tx/vld_tx/rdy_tx - transmitted byte stream
//   dm_addr/dm_din/dm_we - data-memory write port (one-cycle strobe)
//   end_addr          - address after the last word written
module dcp_load_d
  import dcp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  output logic        finish,
  output logic        busy,
  input  logic [7:0]  d_rx,
  input  logic        vld_rx,
  output logic        rdy_rx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  output logic [31:0] end_addr
);

  state_t      state;
  logic [31:0] acc;
  logic [31:0] ptr;
  logic [3:0]  cnt;
  logic        term_cr;
  logic        msg_start;
  logic        msg_err;
  logic        msg_done;

  logic        rx_fire;
  logic        is_hex;
  logic [3:0]  nibble;
  logic [3:0]  cnt_next;

  assign rx_fire  = vld_rx && rdy_rx;
  assign cnt_next = (cnt == 4'd8) ? cnt : cnt + 4'd1;

  // Hex digit decode of the incoming byte
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (d_rx >= 8'h30 && d_rx <= 8'h39) begin
      nibble = d_rx[3:0];
    end else if ((d_rx >= 8'h61 && d_rx <= 8'h66) || (d_rx >= 8'h41 && d_rx <= 8'h46)) begin
      nibble = d_rx[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Command FSM. rdy_rx and busy are registered and updated on each
  // transition so they always match the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= 32'h0;
      ptr       <= 32'h0;
      cnt       <= 4'd0;
      term_cr   <= 1'b0;
      end_addr  <= 32'h0;
      dm_addr   <= 32'h0;
      dm_din    <= 32'h0;
      dm_we     <= 1'b0;
      rdy_rx    <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      msg_start <= 1'b0;
      msg_err   <= 1'b0;
    end else begin
      dm_we     <= 1'b0;
      finish    <= 1'b0;
      msg_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (we) begin
            acc    <= 32'h0;
            cnt    <= 4'd0;
            busy   <= 1'b1;
            rdy_rx <= 1'b1;
            state  <= ST_RX_ADDR;
          end
        end

        ST_RX_ADDR: begin
          if (rx_fire) begin
            if (is_hex) begin
              acc <= {acc[27:0], nibble};
              cnt <= cnt_next;
            end else if (d_rx == ASCII_LF) begin
              state <= ST_RX_ADDR;
            end else if (d_rx == ASCII_SP) begin
              if (cnt != 4'd0) begin
                ptr   <= acc;
                acc   <= 32'h0;
                cnt   <= 4'd0;
                state <= ST_RX_DATA;
              end
            end else if (d_rx == ASCII_CR) begin
              // Address-only line just moves end_addr; empty line is an error
              rdy_rx    <= 1'b0;
              msg_start <= 1'b1;
              state     <= ST_TX_MSG;
              if (cnt == 4'd0) begin
                msg_err <= 1'b1;
              end else begin
                msg_err  <= 1'b0;
                ptr      <= acc;
                end_addr <= acc;
              end
            end else begin
              state <= ST_DRAIN;
            end
          end
        end

        ST_RX_DATA: begin
          if (rx_fire) begin
            if (is_hex) begin
              acc <= {acc[27:0], nibble};
              cnt <= cnt_next;
            end else if (d_rx == ASCII_LF) begin
              state <= ST_RX_DATA;
            end else if (d_rx == ASCII_SP || d_rx == ASCII_CR) begin
              if (cnt != 4'd0) begin
                // Strobe is launched here so it lands in the next cycle
                dm_we   <= 1'b1;
                dm_addr <= ptr;
                dm_din  <= acc;
                term_cr <= (d_rx == ASCII_CR);
                rdy_rx  <= 1'b0;
                state   <= ST_WRITE;
              end else if (d_rx == ASCII_CR) begin
                rdy_rx    <= 1'b0;
                msg_start <= 1'b1;
                msg_err   <= 1'b0;
                state     <= ST_TX_MSG;
              end
            end else begin
              state <= ST_DRAIN;
            end
          end
        end

        ST_WRITE: begin
          ptr      <= ptr + 32'd1;
          end_addr <= ptr + 32'd1;
          acc      <= 32'h0;
          cnt      <= 4'd0;
          if (term_cr) begin
            msg_start <= 1'b1;
            msg_err   <= 1'b0;
            state     <= ST_TX_MSG;
          end else begin
            rdy_rx <= 1'b1;
            state  <= ST_RX_DATA;
          end
        end

        ST_DRAIN: begin
          if (rx_fire && d_rx == ASCII_CR) begin
            rdy_rx    <= 1'b0;
            msg_start <= 1'b1;
            msg_err   <= 1'b1;
            state     <= ST_TX_MSG;
          end
        end

        ST_TX_MSG: begin
          if (msg_done) begin
            finish <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dcp_msg_tx u_msg_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (msg_start),
    .is_err (msg_err),
    .rdy_tx (rdy_tx),
    .d_tx   (d_tx),
    .vld_tx (vld_tx),
    .done   (msg_done)
  );

endmodule
